// File: rtl/time_field_if.sv
// Handshake bundle between the alarm clock control logic and one time-field counter.
// The counter connects through the slave modport, the driving logic through the master modport.
interface time_field_if #(
  parameter int unsigned WIDTH = 6
);
  logic             tick_en;
  logic             adj_up;
  logic             adj_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] value;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             carry;
  logic             adj_active;

  modport master (
    output tick_en, adj_up, adj_dn, load, load_val,
    input  value, tens, ones, carry, adj_active
  );

  modport slave (
    input  tick_en, adj_up, adj_dn, load, load_val,
    output value, tens, ones, carry, adj_active
  );
endinterface

// File: rtl/time_field_counter.sv
// Time-field counter: tick counting with carry out, button adjust with hold-to-repeat,
// parallel load, and wrap or saturate at the limits. Binary and BCD outputs are registered.
module time_field_counter #(
  parameter int unsigned MODULUS      = 60,
  parameter int unsigned BASE         = 0,
  parameter int unsigned WIDTH        = $clog2(BASE + MODULUS),
  parameter bit          WRAP         = 1'b1,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic         clk,
  input  logic         rst,
  time_field_if.slave  bus
);

  localparam int unsigned MAX    = BASE + MODULUS - 1;
  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  localparam logic [WIDTH-1:0] BaseV    = WIDTH'(BASE);
  localparam logic [WIDTH-1:0] MaxV     = WIDTH'(MAX);
  localparam logic [CntW-1:0]  DelayEnd = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0]  RateEnd  = CntW'(REPEAT_RATE - 1);
  localparam logic [3:0]       BaseTens = 4'(BASE / 10);
  localparam logic [3:0]       BaseOnes = 4'(BASE % 10);

  if (MAX > 99) begin : g_bad_range
    $fatal(1, "time_field_counter: BASE+MODULUS-1 exceeds two BCD digits");
  end
  if (REPEAT_DELAY < 2 || REPEAT_RATE < 1) begin : g_bad_repeat
    $fatal(1, "time_field_counter: illegal repeat timing");
  end

  typedef enum logic [1:0] {StIdle, StHold, StRpt} adj_state_e;

  adj_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             armed_q, armed_d;
  logic             adj_active_q, adj_active_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             carry_q, carry_d;

  logic        sole_up, sole_dn, same_dir;
  logic        step, step_up;
  logic [31:0] load_off;
  logic        load_ok;
  logic [31:0] value_int;

  assign sole_up  = bus.adj_up & ~bus.adj_dn;
  assign sole_dn  = bus.adj_dn & ~bus.adj_up;
  assign same_dir = dir_q ? sole_up : sole_dn;

  // Unsigned offset from BASE: out-of-range values on either side land above MODULUS.
  assign load_off = 32'(bus.load_val) - BASE;
  assign load_ok  = load_off < MODULUS;

  // Adjust FSM; armed_q blocks a button still held across reset from stepping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    armed_d = armed_q | (~bus.adj_up & ~bus.adj_dn);
    step    = 1'b0;
    step_up = dir_q;
    case (state_q)
      StIdle: begin
        if (armed_q && (sole_up || sole_dn)) begin
          step    = 1'b1;
          step_up = sole_up;
          dir_d   = sole_up;
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (!same_dir) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == DelayEnd) begin
          step    = 1'b1;
          cnt_d   = '0;
          state_d = StRpt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRpt: begin
        if (!same_dir) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == RateEnd) begin
          step  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
    adj_active_d = (state_d != StIdle);
  end

  // Value update: load beats tick beats adjust step.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (bus.load) begin
      value_d = load_ok ? bus.load_val : BaseV;
    end else if (bus.tick_en) begin
      if (value_q != MaxV) begin
        value_d = value_q + 1'b1;
      end else if (WRAP) begin
        value_d = BaseV;
        carry_d = 1'b1;
      end
    end else if (step) begin
      if (step_up) begin
        if (value_q != MaxV) begin
          value_d = value_q + 1'b1;
        end else if (WRAP) begin
          value_d = BaseV;
        end
      end else begin
        if (value_q != BaseV) begin
          value_d = value_q - 1'b1;
        end else if (WRAP) begin
          value_d = MaxV;
        end
      end
    end
    value_int = 32'(value_d);
    tens_d    = 4'(value_int / 10);
    ones_d    = 4'(value_int % 10);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      armed_q      <= 1'b0;
      adj_active_q <= 1'b0;
      value_q      <= BaseV;
      tens_q       <= BaseTens;
      ones_q       <= BaseOnes;
      carry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      armed_q      <= armed_d;
      adj_active_q <= adj_active_d;
      value_q      <= value_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      carry_q      <= carry_d;
    end
  end

  assign bus.value      = value_q;
  assign bus.tens       = tens_q;
  assign bus.ones       = ones_q;
  assign bus.carry      = carry_q;
  assign bus.adj_active = adj_active_q;

endmodule

// File: tb/tb_time_field_counter.sv
// Directed bench for time_field_counter: three instances cover a 0..59 wrapping field,
// a 1..12 hour field and a saturating 0..59 field.
module tb_time_field_counter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  time_field_if #(.WIDTH(6)) a_if ();
  time_field_if #(.WIDTH(4)) b_if ();
  time_field_if #(.WIDTH(6)) c_if ();

  time_field_counter #(
    .MODULUS(60), .BASE(0), .WIDTH(6), .WRAP(1'b1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  time_field_counter #(
    .MODULUS(12), .BASE(1), .WIDTH(4), .WRAP(1'b1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  time_field_counter #(
    .MODULUS(60), .BASE(0), .WIDTH(6), .WRAP(1'b0), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) u_c (
    .clk (clk),
    .rst (rst),
    .bus (c_if.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int dn_exp[10] = '{59, 59, 59, 59, 59, 58, 58, 57, 57, 56};

  initial begin
    a_if.tick_en = 0; a_if.adj_up = 0; a_if.adj_dn = 0; a_if.load = 0; a_if.load_val = '0;
    b_if.tick_en = 0; b_if.adj_up = 0; b_if.adj_dn = 0; b_if.load = 0; b_if.load_val = '0;
    c_if.tick_en = 0; c_if.adj_up = 0; c_if.adj_dn = 0; c_if.load = 0; c_if.load_val = '0;
    rst = 1'b1;
    step();

    // Reset state
    chk("rst_a_value", a_if.value, 0);
    chk("rst_a_tens", a_if.tens, 0);
    chk("rst_a_ones", a_if.ones, 0);
    chk("rst_a_carry", a_if.carry, 0);
    chk("rst_a_active", a_if.adj_active, 0);
    chk("rst_b_value", b_if.value, 1);
    chk("rst_b_tens", b_if.tens, 0);
    chk("rst_b_ones", b_if.ones, 1);
    chk("rst_c_value", c_if.value, 0);
    rst = 1'b0;
    step();

    // Load 58 then two ticks across the wrap
    a_if.load = 1; a_if.load_val = 6'd58;
    step();
    a_if.load = 0;
    chk("ld58_value", a_if.value, 58);
    chk("ld58_tens", a_if.tens, 5);
    chk("ld58_ones", a_if.ones, 8);
    a_if.tick_en = 1;
    step();
    chk("tick59_value", a_if.value, 59);
    chk("tick59_tens", a_if.tens, 5);
    chk("tick59_ones", a_if.ones, 9);
    chk("tick59_carry", a_if.carry, 0);
    step();
    chk("wrap_value", a_if.value, 0);
    chk("wrap_tens", a_if.tens, 0);
    chk("wrap_ones", a_if.ones, 0);
    chk("wrap_carry", a_if.carry, 1);
    a_if.tick_en = 0;
    step();
    chk("post_wrap_carry", a_if.carry, 0);
    chk("post_wrap_value", a_if.value, 0);

    // 12h field: wrap 12->1 with carry, out-of-range loads go to BASE
    b_if.load = 1; b_if.load_val = 4'd12;
    step();
    b_if.load = 0;
    chk("b_ld12_value", b_if.value, 12);
    chk("b_ld12_tens", b_if.tens, 1);
    chk("b_ld12_ones", b_if.ones, 2);
    b_if.tick_en = 1;
    step();
    b_if.tick_en = 0;
    chk("b_wrap_value", b_if.value, 1);
    chk("b_wrap_carry", b_if.carry, 1);
    b_if.load = 1; b_if.load_val = 4'd5;
    step();
    chk("b_ld5_value", b_if.value, 5);
    b_if.load_val = 4'd0;
    step();
    chk("b_ld0_value", b_if.value, 1);
    b_if.load_val = 4'd5;
    step();
    b_if.load_val = 4'd13;
    step();
    b_if.load = 0;
    chk("b_ld13_value", b_if.value, 1);
    chk("b_ld13_carry", b_if.carry, 0);

    // Hold adj_dn for 10 cycles from value 0
    a_if.adj_dn = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("dn_value_%0d", i), a_if.value, dn_exp[i]);
      chk($sformatf("dn_active_%0d", i), a_if.adj_active, 1);
      chk($sformatf("dn_carry_%0d", i), a_if.carry, 0);
    end
    a_if.adj_dn = 0;
    step();
    chk("dn_release_active", a_if.adj_active, 0);
    chk("dn_release_value", a_if.value, 56);

    // Saturating field at MAX and BASE
    c_if.load = 1; c_if.load_val = 6'd59;
    step();
    c_if.load = 0;
    c_if.tick_en = 1;
    step();
    c_if.tick_en = 0;
    chk("sat_tick_value", c_if.value, 59);
    chk("sat_tick_carry", c_if.carry, 0);
    c_if.adj_up = 1;
    step();
    chk("sat_up_value", c_if.value, 59);
    chk("sat_up_active", c_if.adj_active, 1);
    c_if.adj_up = 0;
    step();
    c_if.load = 1; c_if.load_val = 6'd0;
    step();
    c_if.load = 0;
    c_if.adj_dn = 1;
    step();
    chk("sat_dn_value", c_if.value, 0);
    c_if.adj_dn = 0;
    step();

    // load beats tick and adjust press in the same cycle
    a_if.load = 1; a_if.load_val = 6'd10;
    step();
    a_if.load_val = 6'd30; a_if.tick_en = 1; a_if.adj_up = 1;
    step();
    chk("prio_value", a_if.value, 30);
    chk("prio_carry", a_if.carry, 0);
    a_if.load = 0; a_if.adj_up = 0;
    step();
    a_if.tick_en = 0;
    chk("prio_next_value", a_if.value, 31);

    // Reset in the middle of a repeat interval with the button still held
    step();
    a_if.adj_up = 1;
    step();
    chk("rpt_press_value", a_if.value, 32);
    repeat (4) step();
    chk("rpt_hold_value", a_if.value, 32);
    step();
    chk("rpt_first_value", a_if.value, 33);
    step();
    chk("rpt_mid_active", a_if.adj_active, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_value", a_if.value, 0);
    chk("async_rst_active", a_if.adj_active, 0);
    chk("async_rst_ones", a_if.ones, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("held_after_rst_value_%0d", i), a_if.value, 0);
      chk($sformatf("held_after_rst_active_%0d", i), a_if.adj_active, 0);
    end
    a_if.adj_up = 0;
    step();
    a_if.adj_up = 1;
    step();
    chk("fresh_press_value", a_if.value, 1);
    chk("fresh_press_active", a_if.adj_active, 1);
    a_if.adj_up = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_field_counter.md
Name: time_field_counter

Overview:
- Generalised time-field counter (seconds, minutes, hours in 12h or 24h form) for the alarm clock datapath.
- Counts on timebase ticks and emits one-cycle carry pulses to the next field.
- Supports button-driven up/down adjust with hold-to-repeat, parallel load, and wrap or saturate mode.
- Provides both binary and BCD digit outputs for the display mux.

Parameters:
- MODULUS, 60: number of distinct values in the field.
- BASE, 0: lowest value (1 for 12h hours). Legal range is BASE..BASE+MODULUS-1.
- WIDTH, $clog2(BASE+MODULUS): width of the binary value.
- WRAP, 1: 1 = wrap at the limits; 0 = saturate at the limits.
- REPEAT_DELAY, 50: clk cycles a held button waits before auto-repeat starts (≥2).
- REPEAT_RATE, 10: clk cycles between auto-repeat steps (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tick_en  in  1  timebase pulse; count up one step
- adj_up  in  1  synchronised, debounced level; held = increment
- adj_dn  in  1  synchronised, debounced level; held = decrement
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- value  out  WIDTH  current binary value
- tens  out  4  BCD tens digit of value
- ones  out  4  BCD ones digit of value
- carry  out  1  one-cycle pulse on tick-driven wrap MAX->BASE
- adj_active  out  1  high while the adjust FSM is not IDLE

Behaviour:
- Reset values: value=BASE; tens and ones equal the BCD digits of BASE; carry=0; adj_active=0; FSM=IDLE; repeat counter=0.
- Elaboration: BASE+MODULUS-1 must be ≤99, otherwise generate a fatal error.
- MAX is defined as BASE+MODULUS-1.
- All outputs are registered. value, tens, ones and carry update on the same edge, so there is zero extra latency between the digits and the binary value.
- Per-edge priority, evaluated each cycle:
  - load: value = load_val if BASE ≤ load_val ≤ MAX, else BASE. carry=0.
  - else tick_en:
    - At value<MAX: value+1, carry=0.
    - At MAX with WRAP=1: value=BASE, carry=1.
    - At MAX with WRAP=0: hold, carry=0.
  - else adjust step pending (see FSM): ±1.
    - WRAP=1: wrap in both directions (MAX+1->BASE, BASE-1->MAX).
    - WRAP=0: hold at the limit.
    - carry is never asserted on an adjust step.
  - A step that loses on priority is discarded. FSM timing is unaffected.
- carry is high for exactly one cycle per wrap. It is low in every cycle with no tick-driven wrap, even if tick_en stays low afterwards.
- Adjust FSM (sole = exactly one of adj_up/adj_dn is high):
  - IDLE: on sole press, issue one step in the pressed direction, clear the counter, go to HOLD.
  - HOLD: the counter increments each cycle.
    - Release, both buttons high, or a direction change: go to IDLE with no step.
    - Counter==REPEAT_DELAY-1: issue a step, clear the counter, go to RPT.
  - RPT: same exit rules as HOLD. Counter==REPEAT_RATE-1: issue a step and clear the counter.
  - adj_active is high in HOLD and RPT.
  - A direction change requires the FSM to return to IDLE. A new press is recognised no earlier than the following cycle.
- Both buttons high in IDLE produces no step and no state change.
- load does not affect the FSM.
- tick_en, load and adj_* are sampled only on clk edges. A pulse wider than one cycle counts once per cycle it is high.
- Asynchronous rst at any time, including mid-repeat or in a carry cycle, forces all reset values immediately. The first step after release requires a fresh press.

Test Plan:
- MODULUS=60, BASE=0: load 58, two ticks -> value 59 then 0; tens/ones 5/9 then 0/0; carry high only in the cycle value=0.
- MODULUS=12, BASE=1: load 12, tick -> value 1, carry=1. load 0 -> value 1. load 13 -> value 1.
- value=0, REPEAT_DELAY=5, REPEAT_RATE=2, adj_dn held 10 cycles -> value 59 after the press edge, 58 five cycles later, then 57 and 56 at 2-cycle spacing; carry never high; adj_active high from the cycle after the press until the cycle after release.
- WRAP=0, value=MAX: tick and adj_up -> value stays MAX, carry=0. value=BASE with adj_dn -> stays BASE.
- Same cycle load=1 (val 30), tick_en=1, adj press at value 10 -> value 30, carry 0. The next cycle tick only -> 31.
- rst asserted in RPT mid-interval with adj_up still held -> immediate value=BASE and adj_active=0. After rst deasserts, no step until adj_up is released and pressed again.
